// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package display_pkg;

  typedef enum logic [1:0] {INIT, BLANK, ON} scan_state_t;

  localparam int unsigned MAX_PACKED_W = 256;
  localparam int unsigned MAX_DIGIT_W  = 32;

  // Extract digit k (w bits wide) from a packed, zero-extended digit vector.
  function automatic logic [MAX_DIGIT_W-1:0] digit_slice(
    input logic [MAX_PACKED_W-1:0] packed_val,
    input int unsigned             k,
    input int unsigned             w
  );
    logic [MAX_DIGIT_W-1:0] keep;
    keep = {MAX_DIGIT_W{1'b1}} >> (MAX_DIGIT_W - w);
    return MAX_DIGIT_W'(packed_val >> (k * w)) & keep;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Terminal-count dwell timer shared by the BLANK and ON phases of the scanner.
module dwell_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // A phase of length L occupies counts 0 .. L-1.
  assign done = (count == limit - CNT_W'(1));

endmodule

// File: rtl/display_mux_scanner.sv
// N-digit common-anode display scanner with blanking, per-digit mask and
// frame-coherent snapshot of the digit values.
module display_mux_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned ON_CYCLES    = 2400,
  parameter int unsigned BLANK_CYCLES = 240
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
  localparam int unsigned PACKED_W  = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_DWELL = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_DWELL + 1);
  localparam bit          NO_BLANK  = (BLANK_CYCLES == 0);

  scan_state_t           state;
  logic [IDX_W-1:0]      idx;
  logic [PACKED_W-1:0]   snap_val;
  logic [NUM_DIGITS-1:0] snap_mask;

  logic                  dwell_done;
  logic                  dwell_clear;
  logic [CNT_W-1:0]      dwell_limit;
  logic                  advance;
  logic                  wrap;
  logic [IDX_W-1:0]      nxt_idx;
  logic [PACKED_W-1:0]   nxt_val;
  logic [NUM_DIGITS-1:0] nxt_mask;

  function automatic logic [NUM_DIGITS-1:0] on_pattern(
    input logic [IDX_W-1:0]      k,
    input logic [NUM_DIGITS-1:0] m
  );
    return ~((NUM_DIGITS'(1) << k) & m);
  endfunction

  // Slot sequencing: leaving INIT behaves like wrapping past the last digit.
  always_comb begin
    advance     = (state == INIT) || ((state == ON) && dwell_done);
    wrap        = (state == INIT) || (idx == IDX_W'(NUM_DIGITS - 1));
    nxt_idx     = wrap ? '0 : idx + IDX_W'(1);
    nxt_val     = wrap ? digits_in : snap_val;
    nxt_mask    = wrap ? digit_mask : snap_mask;
    dwell_clear = (state == INIT) || dwell_done;
    dwell_limit = (state == BLANK) ? CNT_W'(BLANK_CYCLES) : CNT_W'(ON_CYCLES);
  end

  dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (dwell_clear),
    .limit (dwell_limit),
    .done  (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT;
      idx         <= '0;
      snap_val    <= '0;
      snap_mask   <= '0;
      anode_n     <= '1;
      digit_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (advance) begin
        idx       <= nxt_idx;
        digit_out <= DIGIT_W'(digit_slice(MAX_PACKED_W'(nxt_val), 32'(nxt_idx), DIGIT_W));
        if (wrap) begin
          snap_val    <= digits_in;
          snap_mask   <= digit_mask;
          frame_start <= 1'b1;
        end
        if (NO_BLANK) begin
          state   <= ON;
          anode_n <= on_pattern(nxt_idx, nxt_mask);
        end else begin
          state   <= BLANK;
          anode_n <= '1;
        end
      end else if ((state == BLANK) && dwell_done) begin
        state   <= ON;
        anode_n <= on_pattern(idx, snap_mask);
      end else if ((state != BLANK) && (state != ON)) begin
        state   <= INIT;
        anode_n <= '1;
      end
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_display_mux_scanner.sv
// Directed bench for display_mux_scanner: instance a has BLANK=1, instance b has BLANK=0.
module tb_display_mux_scanner;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned ON = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits_in = 16'h4321;
  logic [3:0]  digit_mask = 4'hF;

  logic [3:0] dout_a, an_a, dout_b, an_b;
  logic [1:0] idx_a, idx_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_mux_scanner #(.NUM_DIGITS(N), .DIGIT_W(DW), .ON_CYCLES(ON), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_mask(digit_mask),
    .digit_out(dout_a), .anode_n(an_a), .digit_idx(idx_a), .frame_start(fs_a)
  );

  display_mux_scanner #(.NUM_DIGITS(N), .DIGIT_W(DW), .ON_CYCLES(ON), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_mask(digit_mask),
    .digit_out(dout_b), .anode_n(an_b), .digit_idx(idx_b), .frame_start(fs_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Model: position within the frame is plain arithmetic on cycles since INIT was left.
  bit         mv = 1'b0;
  bit         act_m [2];
  int         t_m   [2];
  logic [15:0] fval [2];
  logic [3:0]  fmask[2];
  logic [3:0]  e_an [2];
  logic [3:0]  e_dout[2];
  logic [1:0]  e_idx[2];
  logic        e_fs [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int b, s, per, p, slot, off;
      b   = (i == 0) ? 1 : 0;
      s   = ON + b;
      per = N * s;
      if (!reset) begin
        mv        = 1'b1;
        act_m[i]  = 1'b0;
        e_an[i]   = 4'hF;
        e_dout[i] = 4'h0;
        e_idx[i]  = 2'd0;
        e_fs[i]   = 1'b0;
      end else if (mv) begin
        if (!act_m[i]) begin
          act_m[i] = 1'b1;
          t_m[i]   = 0;
        end else begin
          t_m[i]++;
        end
        if (t_m[i] % per == 0) begin
          fval[i]  = digits_in;
          fmask[i] = digit_mask;
        end
        p         = t_m[i] % per;
        slot      = p / s;
        off       = p % s;
        e_idx[i]  = 2'(slot);
        e_dout[i] = 4'(fval[i] >> (4 * slot));
        e_fs[i]   = (p == 0);
        e_an[i]   = (off < b) ? 4'hF : ~(4'(1 << slot) & fmask[i]);
      end
    end
  end

  logic [3:0] prev_an  [2];
  logic [3:0] prev_dout[2];
  bit         prev_ok  [2] = '{1'b0, 1'b0};

  task automatic check_inst(input int i, input string tag, input logic [3:0] a_an,
                            input logic [3:0] a_dout, input logic [1:0] a_idx, input logic a_fs);
    cmp({tag, ".anode_n"},     32'(a_an),   32'(e_an[i]));
    cmp({tag, ".digit_out"},   32'(a_dout), 32'(e_dout[i]));
    cmp({tag, ".digit_idx"},   32'(a_idx),  32'(e_idx[i]));
    cmp({tag, ".frame_start"}, 32'(a_fs),   32'(e_fs[i]));
    cmp({tag, ".one_low"},     32'($countones(~a_an) <= 1), 32'(1));
    if (prev_ok[i] && (a_an == prev_an[i]) && (a_an != 4'hF))
      cmp({tag, ".digit_hold"}, 32'(a_dout), 32'(prev_dout[i]));
    prev_an[i]   = a_an;
    prev_dout[i] = a_dout;
    prev_ok[i]   = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mv) begin
      check_inst(0, "a", an_a, dout_a, idx_a, fs_a);
      check_inst(1, "b", an_b, dout_b, idx_b, fs_b);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(1);
    cmp("lit.reset.anode", 32'(an_a), 32'h0000000F);
    cmp("lit.reset.digit", 32'(dout_a), 32'h0);
    cmp("lit.reset.fs",    32'(fs_a), 32'h0);
    reset = 1'b1;
    step(1);                                   // t=0
    cmp("lit.t0.fs_a",   32'(fs_a),   32'h1);
    cmp("lit.t0.an_a",   32'(an_a),   32'hF);
    cmp("lit.t0.dout_a", 32'(dout_a), 32'h1);
    cmp("lit.t0.an_b",   32'(an_b),   32'hE);
    cmp("lit.t0.fs_b",   32'(fs_b),   32'h1);
    step(1);                                   // t=1
    cmp("lit.t1.an_a",   32'(an_a),   32'hE);
    step(2);                                   // t=3
    cmp("lit.t3.an_b",   32'(an_b),   32'hD);
    cmp("lit.t3.dout_b", 32'(dout_b), 32'h2);
    step(2);                                   // t=5
    cmp("lit.t5.an_a",   32'(an_a),   32'hD);
    cmp("lit.t5.dout_a", 32'(dout_a), 32'h2);
    cmp("lit.t5.idx_a",  32'(idx_a),  32'h1);
    step(11);                                  // t=16
    cmp("lit.t16.fs_a",  32'(fs_a),   32'h1);
    cmp("lit.t16.dout_a", 32'(dout_a), 32'h1);
    step(5);                                   // t=21, slot 1 of frame 1
    digits_in = 16'h8765;
    step(8);                                   // t=29
    cmp("lit.t29.dout_a", 32'(dout_a), 32'h4);
    cmp("lit.t29.an_a",   32'(an_a),   32'h7);
    step(3);                                   // t=32
    cmp("lit.t32.fs_a",   32'(fs_a),   32'h1);
    cmp("lit.t32.dout_a", 32'(dout_a), 32'h5);
    cmp("lit.t32.dout_b", 32'(dout_b), 32'h7);
    step(8);                                   // t=40
    digit_mask = 4'b1010;
    step(9);                                   // t=49
    cmp("lit.t49.an_a",   32'(an_a),   32'hF);
    step(4);                                   // t=53
    cmp("lit.t53.an_a",   32'(an_a),   32'hD);
    cmp("lit.t53.an_b",   32'(an_b),   32'hD);
    digit_mask = 4'hF;
    step(20);                                  // t=73, slot 2 ON
    cmp("lit.t73.an_a",   32'(an_a),   32'hB);
    reset = 1'b0;
    step(1);
    cmp("lit.rst2.an_a",   32'(an_a),   32'hF);
    cmp("lit.rst2.dout_a", 32'(dout_a), 32'h0);
    cmp("lit.rst2.idx_a",  32'(idx_a),  32'h0);
    cmp("lit.rst2.an_b",   32'(an_b),   32'hF);
    reset = 1'b1;
    step(1);
    cmp("lit.rel2.fs_a",   32'(fs_a),   32'h1);
    cmp("lit.rel2.dout_a", 32'(dout_a), 32'h5);
    cmp("lit.rel2.an_b",   32'(an_b),   32'hE);
    step(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
